// File: rtl/dm_if.sv
// dm_if: M-stage data-memory bus plus the store-trace stream.
//   master: drives address/data/byte enables/PC and trace_ready; sees load data, trace head and flags.
//   slave : the responder side of the same signals.
interface dm_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   m_data_addr;
    logic [31:0]   m_data_wdata;
    logic [3:0]    m_data_byteen;
    logic [31:0]   m_inst_addr;
    logic [31:0]   m_data_rdata;
    logic          trace_valid;
    logic          trace_ready;
    logic [31:0]   trace_pc;
    logic [31:0]   trace_addr;
    logic [31:0]   trace_data;
    logic [3:0]    trace_byteen;
    logic [CW-1:0] trace_count;
    logic          overflow;
    logic          err_addr;

    modport master (
        output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
        input  m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data, trace_byteen,
               trace_count, overflow, err_addr
    );

    modport slave (
        input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
        output m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data, trace_byteen,
               trace_count, overflow, err_addr
    );
endinterface

// File: rtl/dm_responder.sv
// dm_responder: byte-enabled data memory with combinational loads and a store-trace FIFO.
//   clk, reset : clock and synchronous active-high reset
//   bus        : dm_if slave (load/store port, trace head with valid/ready, occupancy, sticky flags)
module dm_responder #(
    parameter int DEPTH_WORDS = 3072,
    parameter int AW          = 12,
    parameter int FIFO_DEPTH  = 8
) (
    input logic clk,
    input logic reset,
    dm_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   mem  [DEPTH_WORDS];
    logic [99:0]   fifo [FIFO_DEPTH];
    logic [PW-1:0] rp, wp;
    logic [CW-1:0] count;
    logic [AW-1:0] idx;
    logic [31:0]   old, merged;
    logic          in_range, store, pop, full, accept;

    always_comb begin
        idx      = bus.m_data_addr[AW+1:2];
        in_range = bus.m_data_addr[31:2] < 30'(DEPTH_WORDS);
        old      = in_range ? mem[idx] : '0;
        merged   = old;
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = bus.m_data_byteen[i] ? bus.m_data_wdata[8*i +: 8] : old[8*i +: 8];
        store    = !reset && bus.m_data_byteen != 4'd0 && in_range;
        pop      = count != '0 && bus.trace_ready;
        full     = count == CW'(FIFO_DEPTH);
        // a pop in the same edge frees the slot, so a full FIFO still accepts
        accept   = store && (!full || pop);
    end

    assign bus.m_data_rdata = old;
    assign bus.trace_valid  = count != '0;
    assign bus.trace_count  = count;
    assign {bus.trace_pc, bus.trace_addr, bus.trace_data, bus.trace_byteen} =
        bus.trace_valid ? fifo[rp] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++)
                mem[i] <= '0;
        end else if (store) begin
            mem[idx] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            fifo[wp] <= {bus.m_inst_addr, bus.m_data_addr[31:2], 2'b00, merged, bus.m_data_byteen};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rp           <= '0;
            wp           <= '0;
            count        <= '0;
            bus.overflow <= 1'b0;
            bus.err_addr <= 1'b0;
        end else begin
            if (accept)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            count <= count + CW'(accept) - CW'(pop);
            if (store && full && !pop)
                bus.overflow <= 1'b1;
            if (bus.m_data_byteen != 4'd0 && !in_range)
                bus.err_addr <= 1'b1;
        end
    end
endmodule
